// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared encodings, defaults and RAW hazard helper for stall_ctrl
package stall_ctrl_pkg;

  // Tuse/Tnew are "cycles until needed / until forwardable"; 3 in Tuse means the operand is unused
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default MDU latencies and counter width (counter must hold the larger latency)
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // One RAW term: a live producer targeting a non-$0 register that D reads before it is ready
  function automatic logic raw_haz(
    input logic       wr,
    input logic [4:0] a3,
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [1:0] tnew
  );
    return wr && (a3 != 5'd0) && (a3 == src) && (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_mdu_timer.sv
// rtl/stall_ctrl_mdu_timer.sv - MDU busy countdown with end-of-operation pulse
import stall_ctrl_pkg::*;

module mdu_timer #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_cancel,
  output logic o_busy,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [CNT_W-1:0] w_load;

  assign w_load = i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Load on an uncancelled start, otherwise count down; an op already counting ignores cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_start && !i_cancel) begin
      r_cnt  <= w_load;
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - 1'b1;
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = r_done;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - D->E hazard/stall controller: RAW and MDU stalls, freeze, stall counter
import stall_ctrl_pkg::*;

module stall_ctrl #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic        E_regWrite,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic        M_regWrite,
  input  logic [1:0]  M_Tnew,
  input  logic        E_start,
  input  logic        E_is_div,
  output logic        freeze,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  logic        w_reg_stall;
  logic        w_md_stall;
  logic        w_freeze;
  logic        w_mdu_busy;
  logic        w_mdu_done;
  logic [31:0] r_stall_cycles;

  mdu_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .i_start  (E_start),
    .i_is_div (E_is_div),
    .i_cancel (Req),
    .o_busy   (w_mdu_busy),
    .o_done   (w_mdu_done)
  );

  // Stall sources; an MDU op entering E already blocks the next HI/LO user, and a flush overrides all
  always_comb begin
    w_reg_stall = raw_haz(E_regWrite, E_A3, D_A1, D_Tuse_rs, E_Tnew)
                | raw_haz(E_regWrite, E_A3, D_A2, D_Tuse_rt, E_Tnew)
                | raw_haz(M_regWrite, M_A3, D_A1, D_Tuse_rs, M_Tnew)
                | raw_haz(M_regWrite, M_A3, D_A2, D_Tuse_rt, M_Tnew);
    w_md_stall  = D_is_md & (w_mdu_busy | E_start);
    w_freeze    = (w_reg_stall | w_md_stall) & ~Req;
  end

  // Saturating count of frozen cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_freeze && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign freeze       = w_freeze;
  assign mdu_busy     = w_mdu_busy;
  assign mdu_done     = w_mdu_done;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed self-checking bench for stall_ctrl
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic        Req;
  logic [4:0]  D_A1, D_A2;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt;
  logic        D_is_md;
  logic [4:0]  E_A3;
  logic        E_regWrite;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_A3;
  logic        M_regWrite;
  logic [1:0]  M_Tnew;
  logic        E_start, E_is_div;
  logic        freeze, mdu_busy, mdu_done;
  logic [31:0] stall_cycles;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_frz  = 1'b0;
  logic [31:0] exp_stalls = 32'd0;

  stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .Req          (Req),
    .D_A1         (D_A1),
    .D_A2         (D_A2),
    .D_Tuse_rs    (D_Tuse_rs),
    .D_Tuse_rt    (D_Tuse_rt),
    .D_is_md      (D_is_md),
    .E_A3         (E_A3),
    .E_regWrite   (E_regWrite),
    .E_Tnew       (E_Tnew),
    .M_A3         (M_A3),
    .M_regWrite   (M_regWrite),
    .M_Tnew       (M_Tnew),
    .E_start      (E_start),
    .E_is_div     (E_is_div),
    .freeze       (freeze),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Set the expected freeze for the current inputs and compare it
  task automatic check_frz(input string tag, input logic exp);
    exp_frz = exp;
    #1;
    check(tag, {31'd0, freeze}, {31'd0, exp});
  endtask

  // Advance one clock: inputs stay as driven, next negedge is where new inputs go
  task automatic tick();
    @(posedge clk);
    if (reset) exp_stalls = 32'd0;
    else if (exp_frz && exp_stalls != 32'hFFFF_FFFF) exp_stalls = exp_stalls + 32'd1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Req = 0; D_A1 = 0; D_A2 = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 0;
    E_A3 = 0; E_regWrite = 0; E_Tnew = 0; M_A3 = 0; M_regWrite = 0; M_Tnew = 0;
    E_start = 0; E_is_div = 0;
    exp_frz = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(negedge clk);
    tick();
    tick();
    check("rst_busy", {31'd0, mdu_busy}, 32'd0);
    check("rst_done", {31'd0, mdu_done}, 32'd0);
    check("rst_stalls", stall_cycles, 32'd0);
    check_frz("rst_freeze", 1'b0);
    reset = 0;
    tick();

    // 1: lw in E feeding add in D, then the producer in M
    E_regWrite = 1; E_A3 = 5'd8; E_Tnew = 2'd2; D_A1 = 5'd8; D_Tuse_rs = 2'd1;
    check_frz("raw_e_rs", 1'b1);
    tick();
    E_regWrite = 0; E_A3 = 0; E_Tnew = 0; M_regWrite = 1; M_A3 = 5'd8; M_Tnew = 2'd1;
    check_frz("raw_m_rs_ready", 1'b0);
    check("stalls_after_raw", stall_cycles, exp_stalls);
    M_Tnew = 2'd2; D_A1 = 0; D_A2 = 5'd8; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd1;
    check_frz("raw_m_rt", 1'b1);
    M_regWrite = 0;
    E_regWrite = 1; E_A3 = 5'd9; E_Tnew = 2'd1; D_A2 = 5'd9; D_Tuse_rt = 2'd0;
    check_frz("raw_e_rt", 1'b1);
    Req = 1;
    check_frz("raw_req_dominates", 1'b0);
    tick();

    // 2: $0 and unused operands never stall; Tnew=3 vs Tuse=2 does
    clear_inputs();
    E_regWrite = 1; E_A3 = 0; D_A1 = 0; D_Tuse_rs = 2'd0; E_Tnew = 2'd2;
    check_frz("zero_reg", 1'b0);
    E_A3 = 5'd5; D_A1 = 5'd5; D_Tuse_rs = 2'd3; E_Tnew = 2'd3;
    check_frz("tuse_none", 1'b0);
    D_Tuse_rs = 2'd2;
    check_frz("tuse2_tnew3", 1'b1);
    tick();
    check("stalls_count", stall_cycles, exp_stalls);

    // 3: mult busy window with a HI/LO user waiting in D
    clear_inputs();
    D_is_md = 1; E_start = 1; E_is_div = 0;
    check_frz("mult_start_frz", 1'b1);
    check("mult_start_busy", {31'd0, mdu_busy}, 32'd0);
    tick();
    E_start = 0;
    for (int i = 1; i <= 5; i++) begin
      check_frz($sformatf("mult_frz_%0d", i), 1'b1);
      check($sformatf("mult_busy_%0d", i), {31'd0, mdu_busy}, 32'd1);
      check($sformatf("mult_done_%0d", i), {31'd0, mdu_done}, 32'd0);
      tick();
    end
    check("mult_end_busy", {31'd0, mdu_busy}, 32'd0);
    check("mult_end_done", {31'd0, mdu_done}, 32'd1);
    check_frz("mult_end_frz", 1'b0);
    tick();
    check("mult_done_clr", {31'd0, mdu_done}, 32'd0);
    check("stalls_mult", stall_cycles, exp_stalls);

    // 4: cancelled div start, then a committed div that runs through a Req pulse
    clear_inputs();
    D_is_md = 1; E_start = 1; E_is_div = 1; Req = 1;
    check_frz("div_cancel_frz", 1'b0);
    tick();
    clear_inputs();
    check("div_cancel_busy", {31'd0, mdu_busy}, 32'd0);
    E_start = 1; E_is_div = 1;
    check_frz("div_start", 1'b0);
    tick();
    E_start = 0;
    for (int i = 1; i <= 10; i++) begin
      Req = (i == 2);
      check($sformatf("div_busy_%0d", i), {31'd0, mdu_busy}, 32'd1);
      check_frz($sformatf("div_frz_%0d", i), 1'b0);
      tick();
    end
    Req = 0;
    check("div_end_busy", {31'd0, mdu_busy}, 32'd0);
    check("div_end_done", {31'd0, mdu_done}, 32'd1);
    tick();

    // 5: reset in the middle of a div
    clear_inputs();
    D_is_md = 1; E_start = 1; E_is_div = 1;
    check_frz("div2_start", 1'b1);
    tick();
    E_start = 0;
    for (int i = 1; i <= 2; i++) begin
      check_frz($sformatf("div2_frz_%0d", i), 1'b1);
      tick();
    end
    check("div2_busy3", {31'd0, mdu_busy}, 32'd1);
    check("div2_stalls", stall_cycles, exp_stalls);
    reset = 1;
    tick();
    check("mid_rst_busy", {31'd0, mdu_busy}, 32'd0);
    check("mid_rst_done", {31'd0, mdu_done}, 32'd0);
    check("mid_rst_stalls", stall_cycles, 32'd0);
    reset = 0;
    D_is_md = 0;
    check_frz("post_rst_frz", 1'b0);
    tick();
    check("post_rst_busy", {31'd0, mdu_busy}, 32'd0);

    // 6: stall counter saturation
    clear_inputs();
    E_regWrite = 1; E_A3 = 5'd3; E_Tnew = 2'd2; D_A1 = 5'd3; D_Tuse_rs = 2'd0;
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    exp_stalls = 32'hFFFF_FFFE;
    check("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    check_frz("sat_frz", 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("sat_%0d", i), stall_cycles, 32'hFFFF_FFFF);
    end
    check("sat_model", stall_cycles, exp_stalls);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
